i2c_disp_sched: RTL and testbench
=================================

Name: i2c_disp_sched

Overview:
Scheduler between the I2C master/slave transaction logic and the 4-digit 7-segment display multiplexer. Each completed transaction (register address, data byte, direction) is captured into a small FIFO. Entries are presented one at a time on the display-input bus, and each entry is held for a programmable number of milliseconds so a human can read bursts of traffic. Overflow is flagged, never silently hidden.

Parameters:
Fclk, 50000, clock frequency in kHz
F1kHz, 1, tick rate in kHz; ms tick period = Fclk/F1kHz cycles
HOLD_MS, 500, ms ticks each entry stays on display (>=1)
DEPTH, 4, FIFO entries, power of 2, >=2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ev_valid  in  1  one-cycle pulse: transaction complete, fields valid
ev_adr  in  8  register address of transaction
ev_dat  in  8  data byte (master write data or slave read data)
ev_rw  in  1  1 = read (slave data), 0 = write (master data)
adr_REG  out  8  displayed address, to display adr_REG
dat_MASTER  out  8  last displayed write data, to display dat_MASTER
dat_SLAVE  out  8  last displayed read data, to display dat_SLAVE
R_W  out  1  displayed direction, to display R_W
busy  out  1  state != IDLE
pending  out  log2(DEPTH)+1  FIFO occupancy
ovf  out  1  sticky: an event was dropped
freeze  in  1  only with DISP_FREEZE_EN, see below

Behaviour:
- Reset (rst sampled high at posedge): all outputs 0, FIFO empty, state IDLE, prescaler = 0, hold counter = 0. Reset mid-hold discards FIFO contents and the displayed entry.
- Prescaler: free-running cnt. tick = (cnt == Fclk/F1kHz). Next cnt = tick ? 1 : cnt+1. First tick occurs Fclk/F1kHz cycles after reset.
- FIFO: DEPTH x 17 bits {rw, adr, dat}. Write and read pointers wrap modulo DEPTH. Occupancy counter runs 0..DEPTH.
- Push: on ev_valid when not full, or when full with a pop in the same cycle. Simultaneous push+pop leaves occupancy unchanged.
- Full with no pop: the event is dropped and ovf is set. ovf clears only on rst.
- FSM:
  - IDLE -> LOAD when pending != 0.
  - LOAD (1 cycle): pop head and update outputs at this edge. adr_REG <= adr, R_W <= rw. If rw, dat_SLAVE <= dat, else dat_MASTER <= dat; the other data output keeps its value. Clear hold counter. -> HOLD.
  - HOLD: hold counter increments on each tick. When tick and counter == HOLD_MS-1: -> LOAD if pending != 0, else -> IDLE.
  - Displayed values persist through IDLE until the next LOAD.
- Latency: ev_valid in cycle 0 with IDLE and FIFO empty -> pending=1 in cycle 1, LOAD in cycle 1, new outputs visible in cycle 2.
- Hold duration: exactly HOLD_MS ticks counted, i.e. between (HOLD_MS-1)*P+1 and HOLD_MS*P cycles, where P = Fclk/F1kHz.
- ev_valid during LOAD/HOLD: normal push; no effect on current hold.
- All widths are unsigned. The hold counter is wide enough for HOLD_MS.

Optional Feature:
DISP_FREEZE_EN
- Defined: input freeze exists. While freeze = 1, the hold counter does not advance and HOLD never exits, so the current entry stays displayed. IDLE->LOAD is also blocked. FIFO pushes and ovf behave normally. Releasing freeze resumes counting from the held value.
- Undefined: no freeze port; behaviour as above with freeze effectively 0.

Test Plan:
- Params Fclk=4, F1kHz=1, HOLD_MS=2, DEPTH=4 throughout. Reset with rst=1 for 2 cycles -> all outputs 0, pending=0, busy=0, ovf=0.
- Single write event adr=0x12, dat=0xA5, rw=0 in cycle 0 -> from cycle 2: adr_REG=0x12, dat_MASTER=0xA5, dat_SLAVE=0x00, R_W=0, busy=1. Returns to IDLE after 2 ticks; outputs retained.
- Write {0x12,0xA5} then read {0x34,0x5C} back-to-back -> second shown only after first hold expires: adr_REG=0x34, dat_SLAVE=0x5C, R_W=1, dat_MASTER stays 0xA5.
- Six events in consecutive cycles from empty -> first popped at LOAD, four buffered, one dropped. ovf=1 and stays 1. Subsequent display order is events 1-5; the dropped one is event 6.
- FIFO full and LOAD pop in the same cycle as ev_valid -> event accepted, pending unchanged at 4, ovf stays 0.
- With DISP_FREEZE_EN: freeze=1 during HOLD for 20 cycles -> adr_REG unchanged and busy=1. After release, exit occurs after the remaining ticks.

Source files
------------

// File: rtl/i2c_disp_sched.sv
// i2c_disp_sched: buffers completed I2C transactions in a small FIFO and
// presents them one at a time to the 7-segment display multiplexer. Each
// entry stays on the display for HOLD_MS millisecond ticks.
// Optional feature: define DISP_FREEZE_EN to add the 'freeze' input, which
// pauses the hold timer and blocks new loads while held high.
module i2c_disp_sched #(
   parameter int Fclk    = 50000,
   parameter int F1kHz   = 1,
   parameter int HOLD_MS = 500,
   parameter int DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ev_valid,
   input  logic [7:0]                 ev_adr,
   input  logic [7:0]                 ev_dat,
   input  logic                       ev_rw,
`ifdef DISP_FREEZE_EN
   input  logic                       freeze,
`endif
   output logic [7:0]                 adr_REG,
   output logic [7:0]                 dat_MASTER,
   output logic [7:0]                 dat_SLAVE,
   output logic                       R_W,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     pending,
   output logic                       ovf
);

   localparam int P  = Fclk / F1kHz;
   localparam int CW = $clog2(P + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int HW = $clog2(HOLD_MS + 1);

   localparam logic [CW-1:0] TICK_AT   = CW'(P);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [AW:0]   OCC_FULL  = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   OCC_ONE   = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MS - 1);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      HOLD
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          tick;
   logic [HW-1:0] hold_cnt;

   logic [16:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          push;
   logic          pop;
   logic          avail;
   logic          frz;
   logic [16:0]   head;

`ifdef DISP_FREEZE_EN
   assign frz = freeze;
`else
   assign frz = 1'b0;
`endif

   // A full FIFO still accepts an event when the head is popped in the same
   // cycle; "avail" looks one edge ahead so an event arriving while IDLE is
   // loaded on the very next cycle.
   assign tick    = (cnt == TICK_AT);
   assign full    = (count == OCC_FULL);
   assign pop     = (state == LOAD);
   assign push    = ev_valid && (!full || pop);
   assign avail   = (count != '0) || push;
   assign head    = mem[rd_ptr];
   assign busy    = (state != IDLE);
   assign pending = count;

   // Free-running millisecond prescaler; counts 1..P after the first period.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= tick ? CNT_ONE : cnt + CNT_ONE;
      end
   end

   // FIFO storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= {ev_rw, ev_adr, ev_dat};
      end
   end

   // FIFO pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + OCC_ONE;
            2'b01:   count <= count - OCC_ONE;
            default: count <= count;
         endcase
         if (ev_valid && !push) begin
            ovf <= 1'b1;
         end
      end
   end

   // Display sequencer: load the FIFO head, then hold it for HOLD_MS ticks.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         adr_REG    <= '0;
         dat_MASTER <= '0;
         dat_SLAVE  <= '0;
         R_W        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (avail && !frz) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               adr_REG <= head[15:8];
               R_W     <= head[16];
               if (head[16]) begin
                  dat_SLAVE <= head[7:0];
               end else begin
                  dat_MASTER <= head[7:0];
               end
               hold_cnt <= '0;
               state    <= HOLD;
            end
            HOLD: begin
               if (tick && !frz) begin
                  hold_cnt <= hold_cnt + HOLD_ONE;
                  if (hold_cnt == HOLD_LAST) begin
                     state <= avail ? LOAD : IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_disp_sched.sv
// tb_i2c_disp_sched: directed scoreboard bench for i2c_disp_sched with a
// 4-cycle millisecond tick, 2-tick hold and a 4-entry FIFO.
module tb_i2c_disp_sched;

   localparam int FCLK  = 4;
   localparam int F1K   = 1;
   localparam int HOLD  = 2;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ev_valid = 1'b0;
   logic [7:0] ev_adr = '0;
   logic [7:0] ev_dat = '0;
   logic       ev_rw = 1'b0;
`ifdef DISP_FREEZE_EN
   logic       freeze = 1'b0;
`endif
   logic [7:0] adr_REG;
   logic [7:0] dat_MASTER;
   logic [7:0] dat_SLAVE;
   logic       R_W;
   logic       busy;
   logic [2:0] pending;
   logic       ovf;

   int checks = 0;
   int failures = 0;

   // Expected display tuples {adr, rw, master, slave} in presentation order.
   logic [24:0] exp_q[$];
   logic [7:0]  model_mst = '0;
   logic [7:0]  model_slv = '0;

   i2c_disp_sched #(
      .Fclk(FCLK),
      .F1kHz(F1K),
      .HOLD_MS(HOLD),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ev_valid(ev_valid),
      .ev_adr(ev_adr),
      .ev_dat(ev_dat),
      .ev_rw(ev_rw),
`ifdef DISP_FREEZE_EN
      .freeze(freeze),
`endif
      .adr_REG(adr_REG),
      .dat_MASTER(dat_MASTER),
      .dat_SLAVE(dat_SLAVE),
      .R_W(R_W),
      .busy(busy),
      .pending(pending),
      .ovf(ovf)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Issues one event (sampled at the next posedge) and records what the
   // display must show when it is loaded, unless it is expected to be dropped.
   task automatic applyStimulus(input logic [7:0] adr, input logic [7:0] dat,
                                input logic rw, input logic drop);
      ev_adr   = adr;
      ev_dat   = dat;
      ev_rw    = rw;
      ev_valid = 1'b1;
      if (!drop) begin
         if (rw) model_slv = dat;
         else    model_mst = dat;
         exp_q.push_back({adr, rw, model_mst, model_slv});
      end
      @(posedge clk);
      #1;
      ev_valid = 1'b0;
   endtask

   task automatic waitNeg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Two-cycle reset, then checks the cleared state in the first free cycle.
   task automatic doReset();
      #2;
      rst      = 1'b1;
      ev_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      model_mst = '0;
      model_slv = '0;
      @(negedge clk);
      checkOutput("rst_adr_REG", 32'(adr_REG), 32'h0);
      checkOutput("rst_dat_MASTER", 32'(dat_MASTER), 32'h0);
      checkOutput("rst_dat_SLAVE", 32'(dat_SLAVE), 32'h0);
      checkOutput("rst_R_W", 32'(R_W), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_pending", 32'(pending), 32'h0);
      checkOutput("rst_ovf", 32'(ovf), 32'h0);
   endtask

   task automatic checkDrained(input string name);
      checkOutput(name, 32'(exp_q.size()), 32'h0);
   endtask

   // Monitor: every change of the displayed tuple is one presented entry.
   initial begin
      logic [24:0] prev;
      logic [24:0] cur;
      logic [24:0] exp;
      prev = '0;
      forever begin
         @(negedge clk);
         cur = {adr_REG, R_W, dat_MASTER, dat_SLAVE};
         if (rst) begin
            prev = cur;
         end else if (cur !== prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_display actual=0x%0h required=none at %0t", cur, $time);
            end else begin
               exp = exp_q.pop_front();
               checkOutput("display_entry", 32'(cur), 32'(exp));
            end
            prev = cur;
         end
      end
   end

   // Directed test sequence.
   initial begin
      // Single write: loaded in cycle 1, shown from cycle 2, idle at cycle 9.
      doReset();
      applyStimulus(8'h12, 8'hA5, 1'b0, 1'b0);
      waitNeg(1);
      checkOutput("t1_pending_c1", 32'(pending), 32'd1);
      checkOutput("t1_busy_c1", 32'(busy), 32'd1);
      waitNeg(1);
      checkOutput("t1_adr_c2", 32'(adr_REG), 32'h12);
      checkOutput("t1_mst_c2", 32'(dat_MASTER), 32'hA5);
      checkOutput("t1_slv_c2", 32'(dat_SLAVE), 32'h00);
      checkOutput("t1_pending_c2", 32'(pending), 32'd0);
      waitNeg(6);
      checkOutput("t1_busy_c8", 32'(busy), 32'd1);
      waitNeg(1);
      checkOutput("t1_busy_c9", 32'(busy), 32'd0);
      checkOutput("t1_adr_kept", 32'(adr_REG), 32'h12);
      checkDrained("t1_drained");

      // Write then read back-to-back: read appears only after the first hold.
      doReset();
      applyStimulus(8'h12, 8'hA5, 1'b0, 1'b0);
      applyStimulus(8'h34, 8'h5C, 1'b1, 1'b0);
      waitNeg(8);
      checkOutput("t2_adr_c9", 32'(adr_REG), 32'h12);
      checkOutput("t2_busy_c9", 32'(busy), 32'd1);
      waitNeg(1);
      checkOutput("t2_adr_c10", 32'(adr_REG), 32'h34);
      checkOutput("t2_slv_c10", 32'(dat_SLAVE), 32'h5C);
      checkOutput("t2_rw_c10", 32'(R_W), 32'd1);
      checkOutput("t2_mst_c10", 32'(dat_MASTER), 32'hA5);
      waitNeg(6);
      checkOutput("t2_busy_c16", 32'(busy), 32'd1);
      waitNeg(1);
      checkOutput("t2_busy_c17", 32'(busy), 32'd0);
      checkDrained("t2_drained");

      // Six events in consecutive cycles: the sixth is dropped.
      doReset();
      applyStimulus(8'h01, 8'h11, 1'b0, 1'b0);
      applyStimulus(8'h02, 8'h22, 1'b1, 1'b0);
      applyStimulus(8'h03, 8'h33, 1'b0, 1'b0);
      applyStimulus(8'h04, 8'h44, 1'b1, 1'b0);
      applyStimulus(8'h05, 8'h55, 1'b0, 1'b0);
      applyStimulus(8'h06, 8'h66, 1'b1, 1'b1);
      waitNeg(1);
      checkOutput("t3_ovf_c6", 32'(ovf), 32'd1);
      checkOutput("t3_pending_c6", 32'(pending), 32'd4);
      waitNeg(35);
      checkOutput("t3_busy_c41", 32'(busy), 32'd0);
      checkOutput("t3_pending_c41", 32'(pending), 32'd0);
      checkOutput("t3_ovf_sticky", 32'(ovf), 32'd1);
      checkOutput("t3_adr_last", 32'(adr_REG), 32'h05);
      checkDrained("t3_drained");

      // Full FIFO with an event arriving in the LOAD cycle: accepted.
      doReset();
      applyStimulus(8'h40, 8'h80, 1'b0, 1'b0);
      applyStimulus(8'h41, 8'h81, 1'b1, 1'b0);
      applyStimulus(8'h42, 8'h82, 1'b0, 1'b0);
      applyStimulus(8'h43, 8'h83, 1'b1, 1'b0);
      applyStimulus(8'h44, 8'h84, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("t4_pending_c9", 32'(pending), 32'd4);
      checkOutput("t4_busy_c9", 32'(busy), 32'd1);
      applyStimulus(8'h45, 8'h85, 1'b1, 1'b0);
      waitNeg(1);
      checkOutput("t4_pending_c10", 32'(pending), 32'd4);
      checkOutput("t4_ovf_c10", 32'(ovf), 32'd0);
      waitNeg(39);
      checkOutput("t4_busy_c49", 32'(busy), 32'd0);
      checkOutput("t4_ovf_end", 32'(ovf), 32'd0);
      checkOutput("t4_adr_last", 32'(adr_REG), 32'h45);
      checkDrained("t4_drained");

      // Reset mid-hold discards the displayed entry and the buffered one.
      doReset();
      applyStimulus(8'h77, 8'h88, 1'b1, 1'b0);
      applyStimulus(8'h78, 8'h89, 1'b0, 1'b0);
      waitNeg(2);
      checkOutput("t5_busy_c3", 32'(busy), 32'd1);
      checkOutput("t5_pending_c3", 32'(pending), 32'd1);
      doReset();
      waitNeg(12);
      checkOutput("t5_busy_after", 32'(busy), 32'd0);
      checkOutput("t5_adr_after", 32'(adr_REG), 32'h00);
      checkDrained("t5_drained");

`ifdef DISP_FREEZE_EN
      // Freeze for 20 cycles during HOLD; counting resumes afterwards.
      doReset();
      applyStimulus(8'h5A, 8'hC3, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      freeze = 1'b1;
      repeat (19) @(posedge clk);
      @(negedge clk);
      checkOutput("t6_busy_frozen", 32'(busy), 32'd1);
      checkOutput("t6_adr_frozen", 32'(adr_REG), 32'h5A);
      @(posedge clk);
      #1;
      freeze = 1'b0;
      waitNeg(6);
      checkOutput("t6_busy_c28", 32'(busy), 32'd1);
      waitNeg(1);
      checkOutput("t6_busy_c29", 32'(busy), 32'd0);
      checkDrained("t6_drained");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
